// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller: screen/state codes, display
// flags, menu modes and the balance ceiling.
package atm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'h1,
    ST_MENU   = 4'h2,
    ST_AMOUNT = 4'h3,
    ST_RESULT = 4'h4,
    ST_LOCKED = 4'hF
  } state_e;

  localparam logic [7:0] FLAG_OK  = 8'h00;
  localparam logic [7:0] FLAG_ERR = 8'hEE;

  localparam logic [1:0] MODE_BALANCE  = 2'b00;
  localparam logic [1:0] MODE_WITHDRAW = 2'b01;
  localparam logic [1:0] MODE_DEPOSIT  = 2'b10;
  localparam logic [1:0] MODE_RESERVED = 2'b11;

  localparam logic [14:0] BALANCE_MAX = 15'd9999;

endpackage

// File: rtl/bin_to_bcd4.sv
// Combinational 14-bit binary to 4-digit BCD converter (double dabble).
module bin_to_bcd4 (
  input  logic [13:0] bin,
  output logic [15:0] bcd
);

  logic [29:0] sr;

  always_comb begin
    sr = {16'b0, bin};
    for (int i = 0; i < 14; i++) begin
      // Adjust every BCD digit that would overflow past 9 on the next shift.
      for (int j = 0; j < 4; j++) begin
        if (sr[14 + 4*j +: 4] >= 4'd5) begin
          sr[14 + 4*j +: 4] = sr[14 + 4*j +: 4] + 4'd3;
        end
      end
      sr = sr << 1;
    end
    bcd = sr[29:14];
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM transaction sequencer: PIN check, balance/withdraw/deposit against an internal
// balance, and the registered display word for the seven-segment driver.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter logic [15:0] PIN_CODE     = 16'h1234,
  parameter int          MAX_TRIES    = 3,
  parameter logic [13:0] INIT_BALANCE = 14'd500,
  parameter int          MSG_HOLD     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] entry_bcd,
  input  logic        enter,
  input  logic        cancel,
  input  logic [1:0]  mode_sel,
  output logic [31:0] disp_data,
  output logic        entry_clr,
  output logic        locked
);

  state_e      state_q, state_d, ret_q, ret_d;
  logic [1:0]  mode_q, mode_d;
  logic [13:0] bal_q, bal_d;
  logic [3:0]  tries_q, tries_d;
  logic [7:0]  hold_q, hold_d;
  logic        err_q, err_d;
  logic [31:0] disp_q, disp_d;
  logic        clr_q, clr_d;
  logic        locked_q, locked_d;

  logic [3:0]  digit_ok;
  logic        entry_ok;
  logic [13:0] amt;
  logic [14:0] sum;
  logic [15:0] bal_bcd;
  logic [7:0]  flag;
  logic [15:0] value;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_ok[gi] = (entry_bcd[4*gi +: 4] <= 4'd9);
    end
  endgenerate

  assign entry_ok = &digit_ok;
  assign amt = 14'(entry_bcd[15:12]) * 14'd1000 + 14'(entry_bcd[11:8]) * 14'd100
             + 14'(entry_bcd[7:4]) * 14'd10 + 14'(entry_bcd[3:0]);
  assign sum = {1'b0, bal_q} + {1'b0, amt};

  bin_to_bcd4 u_bcd (
    .bin (bal_d),
    .bcd (bal_bcd)
  );

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    mode_d  = mode_q;
    bal_d   = bal_q;
    tries_d = tries_q;
    hold_d  = hold_q;
    err_d   = err_q;
    clr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          clr_d = 1'b1;
        end else if (enter) begin
          clr_d = 1'b1;
          if (entry_ok && entry_bcd == PIN_CODE) begin
            state_d = ST_MENU;
            tries_d = 4'd0;
          end else begin
            tries_d = tries_q + 4'd1;
            if (tries_d == 4'(MAX_TRIES)) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_RESULT;
              err_d   = 1'b1;
              ret_d   = ST_IDLE;
              hold_d  = 8'(MSG_HOLD - 1);
            end
          end
        end
      end
      ST_MENU: begin
        if (cancel) begin
          clr_d   = 1'b1;
          state_d = ST_IDLE;
          tries_d = 4'd0;
        end else if (enter) begin
          clr_d = 1'b1;
          if (mode_sel == MODE_WITHDRAW || mode_sel == MODE_DEPOSIT) begin
            state_d = ST_AMOUNT;
            mode_d  = mode_sel;
          end else begin
            state_d = ST_RESULT;
            err_d   = (mode_sel == MODE_RESERVED);
            ret_d   = ST_MENU;
            hold_d  = 8'(MSG_HOLD - 1);
          end
        end
      end
      ST_AMOUNT: begin
        if (cancel) begin
          clr_d   = 1'b1;
          state_d = ST_MENU;
        end else if (enter) begin
          clr_d   = 1'b1;
          state_d = ST_RESULT;
          ret_d   = ST_MENU;
          hold_d  = 8'(MSG_HOLD - 1);
          // Range-check before committing so the balance can never wrap.
          if (mode_q == MODE_WITHDRAW) begin
            err_d = !entry_ok || amt == 14'd0 || amt > bal_q;
            if (!err_d) bal_d = bal_q - amt;
          end else begin
            err_d = !entry_ok || amt == 14'd0 || sum > BALANCE_MAX;
            if (!err_d) bal_d = sum[13:0];
          end
        end
      end
      ST_RESULT: begin
        if (enter || cancel) begin
          clr_d   = 1'b1;
          state_d = ret_q;
        end else if (hold_q == 8'd0) begin
          state_d = ret_q;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      ST_LOCKED: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    locked_d = (state_d == ST_LOCKED);
    flag     = (locked_d || (state_d == ST_RESULT && err_d)) ? FLAG_ERR : FLAG_OK;
    case (state_d)
      ST_MENU:              value = {14'b0, mode_sel};
      ST_RESULT, ST_LOCKED: value = bal_bcd;
      default:              value = entry_bcd;
    endcase
    disp_d = {state_d, 4'(MAX_TRIES) - tries_d, flag, value};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ret_q    <= ST_IDLE;
      mode_q   <= MODE_BALANCE;
      bal_q    <= INIT_BALANCE;
      tries_q  <= 4'd0;
      hold_q   <= 8'd0;
      err_q    <= 1'b0;
      disp_q   <= {4'h1, 4'(MAX_TRIES), FLAG_OK, 16'h0000};
      clr_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      mode_q   <= mode_d;
      bal_q    <= bal_d;
      tries_q  <= tries_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      disp_q   <= disp_d;
      clr_q    <= clr_d;
      locked_q <= locked_d;
    end
  end

  assign disp_data = disp_q;
  assign entry_clr = clr_q;
  assign locked    = locked_q;

endmodule
